// File: rtl/ctrl_wback.sv
// ctrl_wback: write-back controller; buffers up to 2 activation beats and serializes lanes into one memory write per cycle
//   Optional feature macro: WBACK_OVF_CHECK_EN (sticky err_ovf on dropped beat; otherwise err_ovf tied 0)
//   Ports: clk, rst (sync active-high), in_ctrl {start,valid,stop}, in_data (N_LANE*DWID),
//          out_base/out_size (sampled on start), mem_we/mem_addr/mem_wdata (write port),
//          busy (start..done), done (1-cycle pulse), err_ovf (sticky overflow)
package ctrl_wback_pkg;
  typedef struct packed {
    logic start;
    logic valid;
    logic stop;
  } ctrl_bus;
endpackage

module ctrl_wback
  import ctrl_wback_pkg::*;
#(
  parameter int N_LANE = 16,
  parameter int DWID   = 16,
  parameter int AWID   = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  ctrl_bus                in_ctrl,
  input  logic [N_LANE*DWID-1:0] in_data,
  input  logic [AWID-1:0]        out_base,
  input  logic [AWID-1:0]        out_size,
  output logic                   mem_we,
  output logic [AWID-1:0]        mem_addr,
  output logic [DWID-1:0]        mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err_ovf
);
  localparam int LW = $clog2(N_LANE);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [N_LANE*DWID-1:0] fifo [2];
  logic [N_LANE*DWID-1:0] head;
  logic [1:0] cnt;
  logic rp, wp, stop_seen, issue, wr_ok, pop, push, take_start;
  logic [LW-1:0] lane;
  logic [AWID-1:0] base, size, wcount;
  // The head entry is serialized in place; it is popped on its last issued lane or when the layer is full.
  assign take_start = state_q == IDLE && in_ctrl.start;
  assign head = fifo[rp];
  assign issue = state_q == RUN && cnt != 2'd0;
  assign wr_ok = wcount < size;
  assign pop = issue && (!wr_ok || lane == LW'(N_LANE - 1));
  assign push = state_q == RUN && in_ctrl.valid && (cnt != 2'd2 || pop);
  // A valid arriving in the last RUN cycle holds off FIN so the beat is never stranded in the FIFO.
  always_comb begin
    state_d = state_q == IDLE ? (in_ctrl.start ? RUN : IDLE) :
              state_q == RUN ? ((stop_seen && cnt == 2'd0 && !in_ctrl.valid) ? FIN : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt       <= 2'd0;
      rp        <= 1'b0;
      wp        <= 1'b0;
      lane      <= '0;
      wcount    <= '0;
      base      <= '0;
      size      <= '0;
      stop_seen <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= state_d != IDLE;
      done    <= state_d == FIN;
      mem_we  <= issue && wr_ok;
      if (issue && wr_ok) begin
        mem_addr  <= base + wcount;
        mem_wdata <= head[lane*DWID +: DWID];
        wcount    <= wcount + 1'b1;
      end
      lane <= pop ? '0 : issue ? lane + 1'b1 : lane;
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (take_start) begin
        base      <= out_base;
        size      <= out_size;
        wcount    <= '0;
        stop_seen <= 1'b0;
      end else if (state_q == RUN && in_ctrl.stop) stop_seen <= 1'b1;
    end
  end
`ifdef WBACK_OVF_CHECK_EN
  logic drop;
  assign drop = state_q == RUN && in_ctrl.valid && !push;
  always_ff @(posedge clk) begin
    if (rst || take_start) err_ovf <= 1'b0;
    else if (drop) err_ovf <= 1'b1;
  end
`else
  assign err_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_ctrl_wback.sv
// tb_ctrl_wback: randomized scoreboard bench for ctrl_wback against a timing-aware beat model
module tb_ctrl_wback;
  import ctrl_wback_pkg::*;
  localparam int N = 16, DW = 16, AW = 12;
  logic clk = 1'b0, rst = 1'b1;
  ctrl_bus in_ctrl = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [AW-1:0] out_base = '0, out_size = '0;
  logic mem_we, busy, done, err_ovf;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  typedef struct {
    int cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t q[$];
  int f_list[$];
  int checks = 0, errors = 0, edge_n = 0, ndone = 0, exp_ndone = 0, done_edge = -1;
  int last_f = 0, wc = 0, m_size = 0;
  logic [AW-1:0] m_base = '0;
  bit ovf_exp = 0;

  ctrl_wback #(.N_LANE(N), .DWID(DW), .AWID(AW)) dut (
    .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_base(out_base), .out_size(out_size), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every write must match the next scoreboard entry, including the edge it was issued on.
  always @(negedge clk) begin
    wr_t x;
    if (mem_we === 1'b1) begin
      chk("wr_expected", longint'(q.size() != 0), 1);
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("wr_cyc_addr_data", longint'({edge_n, mem_addr, mem_wdata}), longint'({x.cyc, x.a, x.d}));
      end
    end
    if (done === 1'b1) begin
      ndone++;
      chk("done_cycle", edge_n, done_edge);
    end
  end

  function automatic longint ovf_model();
`ifdef WBACK_OVF_CHECK_EN
    return longint'(ovf_exp);
`else
    return 0;
`endif
  endfunction

  function automatic logic [N*DW-1:0] rnd();
    logic [N*DW-1:0] d;
    for (int j = 0; j < N; j++) d[j*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_ctrl = '0;
    tick();
    rst = 1'b0;
    f_list.delete();
    last_f = 0;
    wc = 0;
    ovf_exp = 0;
    done_edge = -1;
    exp_ndone = ndone;
  endtask

  task automatic start(input logic [AW-1:0] b, input logic [AW-1:0] s, input bit accept);
    in_ctrl.start = 1'b1;
    out_base = b;
    out_size = s;
    if (accept) begin
      m_base = b;
      m_size = s;
      wc = 0;
      ovf_exp = 0;
    end
    tick();
    in_ctrl.start = 1'b0;
    out_base = AW'($urandom);
    out_size = AW'($urandom);
    chk("busy_after_start", busy, 1);
  endtask

  // Beat model: a beat is dropped when two earlier beats are still held past its arrival edge;
  // otherwise it starts issuing the edge after both its arrival and the previous beat's release.
  task automatic beat(input logic [N*DW-1:0] d, input bit stp);
    int e, held, s, n;
    wr_t w;
    e = edge_n + 1;
    held = 0;
    in_ctrl.valid = 1'b1;
    in_ctrl.stop = stp;
    in_data = d;
    foreach (f_list[i]) if (f_list[i] > e) held++;
    if (held >= 2) ovf_exp = 1;
    else begin
      s = (last_f + 1 > e + 1) ? last_f + 1 : e + 1;
      n = m_size - wc;
      if (n > N) n = N;
      for (int j = 0; j < n; j++) begin
        w.cyc = s + j;
        w.a = m_base + AW'(wc + j);
        w.d = d[j*DW +: DW];
        q.push_back(w);
      end
      wc += n;
      last_f = s + ((n == N) ? N : n + 1) - 1;
      f_list.push_back(last_f);
    end
    if (stp) begin
      done_edge = ((last_f > e) ? last_f : e) + 1;
      exp_ndone++;
    end
    tick();
    in_ctrl = '0;
  endtask

  task automatic stop();
    int e;
    e = edge_n + 1;
    in_ctrl.stop = 1'b1;
    done_edge = ((last_f > e) ? last_f : e) + 1;
    exp_ndone++;
    tick();
    in_ctrl.stop = 1'b0;
  endtask

  task automatic finish_layer();
    for (int i = 0; i < 300 && ndone < exp_ndone; i++) tick();
    chk("done_count", ndone, exp_ndone);
    tick();
    chk("busy_idle", busy, 0);
    chk("queue_drained", q.size(), 0);
    chk("err_ovf", err_ovf, ovf_model());
  endtask

  task automatic layer(input logic [AW-1:0] b, input logic [AW-1:0] s, input int nb, input int gap, input bit stop_last);
    start(b, s, 1);
    tick();
    for (int i = 0; i < nb; i++) begin
      beat(rnd(), stop_last && i == nb - 1);
      if (i < nb - 1) tick(gap - 1);
    end
    if (!stop_last) stop();
    finish_layer();
  endtask

  initial begin
    int k;
    tick(2);
    do_reset();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_ovf", err_ovf, 0);
    layer(12'h100, 12'd32, 2, 20, 0);
    layer(AW'($urandom), 12'd20, 2, 1, 0);
    layer(AW'($urandom), 12'd48, 3, 4, 0);
    layer(12'hFF8, 12'd16, 1, 1, 0);
    start(AW'($urandom), 12'd32, 1);
    tick();
    beat(rnd(), 0);
    beat(rnd(), 0);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      if (mem_we) k++;
      if (k == 5) break;
      tick();
    end
    chk("writes_before_rst", k, 5);
    while (q.size() > 1) void'(q.pop_back());
    do_reset();
    chk("abort_mem_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    tick(3);
    chk("abort_quiet", mem_we, 0);
    chk("abort_queue", q.size(), 0);
    layer(AW'($urandom), 12'd40, 3, 17, 0);
    start(AW'($urandom), 12'd0, 1);
    start(AW'($urandom), 12'd9, 0);
    beat(rnd(), 1);
    finish_layer();
    for (int r = 0; r < 10; r++)
      layer(AW'($urandom), AW'($urandom_range(0, 70)), $urandom_range(1, 4), $urandom_range(1, 20), 1'($urandom_range(0, 1)));
    chk("queue_final", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
